// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 asynchronous serial receiver with 16x oversampling, false-start
// rejection and a first-word-fall-through receive FIFO.
//
// Optional feature (compile-time macro): UART_RX_PARITY_EN
//   defined     -> an even-parity bit follows the data bits (8E1). A parity
//                  mismatch pulses parity_err and the byte is discarded.
//   not defined -> 8N1 only; parity_err is tied 0.
//
// Parameters:
//   SYS_CLK_FREQ     clk frequency in Hz
//   BAUD_RATE        line bit rate
//   FIFO_DEPTH_LOG2  FIFO holds 2**FIFO_DEPTH_LOG2 bytes
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   rx          serial line, idle high, asynchronous to clk
//   rd_en       pop FIFO head (ignored while empty)
//   rd_data     FIFO head byte, valid while empty = 0 (0 when empty)
//   empty/full  FIFO status
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: good byte dropped, FIFO full
//   parity_err  one-cycle pulse: parity mismatch (0 without the macro)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int SYS_CLK_FREQ    = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int PW      = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer and start-edge detection
  // ---------------------------------------------------------------------------
  logic       sync1_q, rxs_q;
  logic       rxs_prev_q, rxs_prev_d;
  logic [1:0] flush_q, flush_d;
  logic       settled;
  logic       start_edge;

  // The synchronizer resets to 1, so its first two post-reset values are not
  // real line samples. rxs_prev only tracks the line once the pipeline has
  // flushed, which means a falling edge is recognised only after rxs has
  // actually been seen high (a line held low through reset never triggers).
  assign settled    = (flush_q == 2'd2);
  assign start_edge = settled && rxs_prev_q && !rxs_q;

  // NOTE: every always_comb assigns a default to each output first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    flush_d    = settled ? flush_q : flush_q + 2'd1;
    rxs_prev_d = settled ? rxs_q : 1'b0;
  end

  // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
  // pre-edge value; combinational blocks use blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b0;
      flush_q    <= 2'd0;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_prev_d;
      flush_q    <= flush_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM: state register / next-state logic / output logic
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tick;
  logic             bit_end;
  logic             push, pop;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  assign tick    = (state_q != ST_IDLE) && (div_cnt_q == DIV_MAX);
  // 16th tick of a bit period: the sampling point for data/parity/stop bits.
  assign bit_end = tick && (tick_cnt_q == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;

    case (state_q)
      ST_IDLE: begin
        div_cnt_d  = '0;
        tick_cnt_d = '0;
        if (start_edge) state_d = ST_START;
      end
      ST_START: begin
        // Midpoint of the start bit: line must still be low.
        if (tick && (tick_cnt_q == 4'd7)) begin
          tick_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        // Even parity: parity bit equals XOR of the data bits.
        if (bit_end) state_d = (rxs_q == ^shift_q) ? ST_STOP : ST_IDLE;
      end
`endif
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q, parity_err_d;
`endif

  always_comb begin
    push        = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    if ((state_q == ST_PARITY) && bit_end && (rxs_q != ^shift_q)) parity_err_d = 1'b1;
`endif
    if ((state_q == ST_STOP) && bit_end) begin
      if (!rxs_q) begin
        frame_err_d = 1'b1;
      end else if (!full || pop) begin
        // A pop in the same cycle frees the slot being written.
        push = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FWFT FIFO: pointers carry one extra MSB to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign pop   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers empties the
  // FIFO, and rd_data is masked to 0 while empty so stale contents never show.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-2:0]] <= shift_q;
  end

  assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q[PW-2:0]];

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at DIV = 1 (16 MHz clock, 1 Mbaud, one bit =
// 16 clocks) with a 4-entry FIFO. Inputs change on the falling clock edge and
// outputs are sampled on the falling edge. Define UART_RX_PARITY_EN for both
// bench and RTL to exercise the 8E1 build.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CLK_HZ = 16000000;
  localparam int BAUD   = 1000000;
  localparam int DLOG2  = 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_CYC = 16;
`else
  localparam int PAR_CYC = 0;
`endif
  // Cycles from the rx falling edge to the stop-bit sample.
  localparam int STOP_LAT = 155 + PAR_CYC;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full, frame_err, overrun, parity_err;

  uart_rx #(
    .SYS_CLK_FREQ   (CLK_HZ),
    .BAUD_RATE      (BAUD),
    .FIFO_DEPTH_LOG2(DLOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Cycle counts of each flag being high; a clean one-cycle pulse adds 1.
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, ne_cnt = 0;
  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (overrun)    ov_cnt++;
    if (parity_err) pe_cnt++;
    if (!empty)     ne_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame LSB first; rx is left at the stop-bit level afterwards.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    logic [10:0] frame;
    int          nb;
    frame = {stop_bit, (^d) ^ par_flip, d, 1'b0};
    nb    = (PAR_CYC != 0) ? 11 : 10;
    if (nb == 10) frame[9] = stop_bit;
    for (int i = 0; i < nb; i++) begin
      rx = frame[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  int lat;
  int fe0, ov0, pe0, ne0;

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    idle(3);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    rst = 1'b0;
    idle(5);

    // ---- 0xA5: latency from start edge to empty falling --------------------
    fe0 = fe_cnt; ov0 = ov_cnt;
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1, 1'b0);
      begin
        for (int i = 1; i <= STOP_LAT + 40; i++) begin
          @(negedge clk);
          if (!empty && lat == 0) lat = i;
        end
      end
    join
    check("a5_empty_fall_in_window", (lat >= STOP_LAT - 1) && (lat <= STOP_LAT + 2), 1);
    check("a5_rd_data", rd_data, 8'hA5);
    check("a5_full", full, 0);
    pop();
    check("a5_empty_after_pop", empty, 1);
    check("a5_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // ---- false start: low pulse that ends before the start-bit midpoint ---
    // rxs lags rx by two clocks and the midpoint sample lands ~9 clocks after
    // the fall, so a 6-clock pulse is already high again when sampled.
    fe0 = fe_cnt; ov0 = ov_cnt; ne0 = ne_cnt;
    rx = 1'b0;
    idle(6);
    rx = 1'b1;
    idle(40);
    check("glitch_no_push", ne_cnt - ne0, 0);
    check("glitch_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    send_byte(8'h3C, 1'b1, 1'b0);
    idle(4);
    check("3c_rd_data", rd_data, 8'h3C);
    pop();
    check("3c_empty_after_pop", empty, 1);

    // ---- framing error, then line held low ---------------------------------
    fe0 = fe_cnt; ne0 = ne_cnt; ov0 = ov_cnt;
    send_byte(8'h55, 1'b0, 1'b0);
    idle(400);
    check("fe_single_pulse", fe_cnt - fe0, 1);
    check("fe_nothing_pushed", ne_cnt - ne0, 0);
    check("fe_no_overrun", ov_cnt - ov0, 0);
    rx = 1'b1;
    idle(40);
    check("fe_low_line_no_retrigger", fe_cnt - fe0, 1);
    check("fe_empty", empty, 1);

    // ---- fill FIFO, overrun on 5th byte ------------------------------------
    ov0 = ov_cnt;
    for (int b = 1; b <= 3; b++) send_byte(8'(b), 1'b1, 1'b0);
    idle(2);
    check("fill3_not_full", full, 0);
    send_byte(8'h04, 1'b1, 1'b0);
    idle(2);
    check("fill4_full", full, 1);
    send_byte(8'h05, 1'b1, 1'b0);
    idle(2);
    check("ovr_single_pulse", ov_cnt - ov0, 1);
    check("ovr_still_full", full, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_read_%0d", i), rd_data, 32'(i));
      pop();
    end
    check("ovr_drained_empty", empty, 1);

    // ---- full FIFO with pop in the push cycle: byte kept -------------------
    for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1, 1'b0);
    idle(2);
    check("refill_full", full, 1);
    ov0 = ov_cnt;
    fork
      send_byte(8'h05, 1'b1, 1'b0);
      begin
        repeat (STOP_LAT - 1) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    idle(2);
    check("pushpop_no_overrun", ov_cnt - ov0, 0);
    check("pushpop_full_kept", full, 1);
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("pushpop_read_%0d", i), rd_data, 32'(i));
      pop();
    end
    check("pushpop_drained_empty", empty, 1);

    // ---- reset mid-frame ----------------------------------------------------
    send_byte(8'h42, 1'b1, 1'b0);
    idle(2);
    check("pre_reset_nonempty", empty, 0);
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_byte(8'hFF, 1'b1, 1'b0);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b1;
        #1;
        check("inrst_rd_data", rd_data, 8'h00);
        check("inrst_empty", empty, 1);
        check("inrst_full", full, 0);
        check("inrst_flags", {frame_err, overrun, parity_err}, 3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(20);
    check("postrst_empty", empty, 1);
    send_byte(8'h81, 1'b1, 1'b0);
    idle(2);
    check("postrst_rd_data", rd_data, 8'h81);
    pop();
    check("postrst_only_one_byte", empty, 1);
    check("postrst_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

`ifdef UART_RX_PARITY_EN
    // ---- parity: 0x07 has odd weight, so even parity bit is 1 -------------
    pe0 = pe_cnt;
    send_byte(8'h07, 1'b1, 1'b0);
    idle(2);
    check("par_ok_rd_data", rd_data, 8'h07);
    check("par_ok_no_err", pe_cnt - pe0, 0);
    pop();
    ne0 = ne_cnt;
    send_byte(8'h07, 1'b1, 1'b1);
    idle(10);
    check("par_bad_single_pulse", pe_cnt - pe0, 1);
    check("par_bad_nothing_pushed", ne_cnt - ne0, 0);
`else
    pe0 = 0;
    check("parity_err_never", pe_cnt - pe0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
